// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants and state encoding for the LCD update arbiter
// Contents: LCD_ROW_W (bits per 16-char row), LCD_BLANK_ROW (all ASCII spaces),
//           lcd_state_t (arbiter sequencing states).
package lcd_pkg;

    localparam int LCD_ROW_W = 128;
    localparam logic [LCD_ROW_W-1:0] LCD_BLANK_ROW = {16{8'h20}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        HOLDOFF = 3'd4
    } lcd_state_t;

endpackage

// File: rtl/lcd_update_arbiter_if.sv
// rtl/lcd_update_arbiter_if.sv - requester and LCD-driver signal bundle for the arbiter
// Signals: req/row1_in/row2_in/force_req  requester requests, packed rows, dedup bypass
//          grant/done/err                  per-requester grant and completion pulses
//          lcd_ena/row1/row2/lcd_busy      LCD driver handshake and latched rows
// Modports: slave = arbiter side, master = requesters + driver side.
interface lcd_update_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import lcd_pkg::*;

    logic [NUM_REQ-1:0]           req;
    logic [LCD_ROW_W*NUM_REQ-1:0] row1_in;
    logic [LCD_ROW_W*NUM_REQ-1:0] row2_in;
    logic [NUM_REQ-1:0]           force_req;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           done;
    logic [NUM_REQ-1:0]           err;
    logic                         lcd_ena;
    logic [LCD_ROW_W-1:0]         row1;
    logic [LCD_ROW_W-1:0]         row2;
    logic                         lcd_busy;

    modport slave (
        input  req, row1_in, row2_in, force_req, lcd_busy,
        output grant, done, err, lcd_ena, row1, row2
    );

    modport master (
        output req, row1_in, row2_in, force_req, lcd_busy,
        input  grant, done, err, lcd_ena, row1, row2
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker: first set request at or after a registered pointer
// Ports: clk, rst       clock, synchronous active-high reset (pointer -> 0)
//        req            request vector
//        advance        move the pointer to adv_idx+1 (mod N)
//        adv_idx        index of the requester just served
//        gnt/gnt_idx    one-hot winner and its index (combinational)
//        gnt_valid      any request pending
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] adv_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    int            scan;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(adv_idx) == N - 1) ? '0 : adv_idx + IW'(1);
        end
    end

    // Scan N slots starting at ptr, wrapping; the first pending one wins.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        scan      = 0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            scan = int'(ptr) + k;
            if (scan >= N) begin
                scan = scan - N;
            end
            cand = IW'(scan);
            if (!gnt_valid && req[cand]) begin
                gnt_valid  = 1'b1;
                gnt_idx    = cand;
                gnt[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_update_arbiter.sv
// rtl/lcd_update_arbiter.sv - shares one character-LCD driver among NUM_REQ frame producers
// Ports: clk  system clock
//        rst  synchronous active-high reset
//        bus  lcd_update_arbiter_if.slave: requests/rows/force in, grant/done/err out,
//             lcd_ena/row1/row2 to the driver, lcd_busy (asynchronous) from the driver
module lcd_update_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLDOFF_CYC = 50000,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int DEDUP_EN    = 1
) (
    input logic                 clk,
    input logic                 rst,
    lcd_update_arbiter_if.slave bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(HOLDOFF_CYC) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    lcd_state_t           state;
    logic                 busy_m, busy_s;
    logic [NUM_REQ-1:0]   grant_r, done_r, err_r;
    logic                 ena_r;
    logic [LCD_ROW_W-1:0] row1_r, row2_r, last1, last2;
    logic                 last_valid;
    logic                 force_l;
    logic [IW-1:0]        win_idx;
    logic                 armed;
    logic [HW-1:0]        hcnt;
    logic [TW-1:0]        tcnt;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_valid;
    logic [LCD_ROW_W-1:0] sel_row1, sel_row2;
    logic                 sel_force;
    logic                 skip, hit, tout, finish;

    // lcd_busy comes from the driver's 1 MHz domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            busy_m <= bus.lcd_busy;
            busy_s <= busy_m;
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.req),
        .advance  (finish),
        .adv_idx  (win_idx),
        .gnt      (arb_gnt),
        .gnt_idx  (arb_idx),
        .gnt_valid(arb_valid)
    );

    always_comb begin
        sel_row1  = LCD_BLANK_ROW;
        sel_row2  = LCD_BLANK_ROW;
        sel_force = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_row1  = bus.row1_in[i*LCD_ROW_W +: LCD_ROW_W];
                sel_row2  = bus.row2_in[i*LCD_ROW_W +: LCD_ROW_W];
                sel_force = bus.force_req[i];
            end
        end
    end

    // hit: the edge the current handshake phase is waiting for. In START before
    // arming we are still waiting for a busy driver to go idle, which only arms.
    always_comb begin
        skip   = (DEDUP_EN != 0) && last_valid && !force_l &&
                 (row1_r == last1) && (row2_r == last2);
        hit    = (state == START) ? (armed && busy_s) : !busy_s;
        tout   = ((state == START) || (state == WAIT)) && !hit &&
                 (tcnt == TW'(TIMEOUT_CYC - 1));
        finish = ((state == CHECK) && skip) || ((state == WAIT) && hit) || tout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_r    <= '0;
            done_r     <= '0;
            err_r      <= '0;
            ena_r      <= 1'b0;
            row1_r     <= LCD_BLANK_ROW;
            row2_r     <= LCD_BLANK_ROW;
            last1      <= LCD_BLANK_ROW;
            last2      <= LCD_BLANK_ROW;
            last_valid <= 1'b0;
            force_l    <= 1'b0;
            win_idx    <= '0;
            armed      <= 1'b0;
            hcnt       <= '0;
            tcnt       <= '0;
        end else begin
            done_r <= '0;
            err_r  <= '0;
            if (tout) begin
                err_r      <= grant_r;
                ena_r      <= 1'b0;
                grant_r    <= '0;
                last_valid <= 1'b0;
                hcnt       <= '0;
                state      <= HOLDOFF;
            end else begin
                case (state)
                    IDLE: begin
                        if (arb_valid) begin
                            win_idx <= arb_idx;
                            grant_r <= arb_gnt;
                            row1_r  <= sel_row1;
                            row2_r  <= sel_row2;
                            force_l <= sel_force;
                            state   <= CHECK;
                        end
                    end
                    CHECK: begin
                        tcnt <= '0;
                        if (skip) begin
                            done_r  <= grant_r;
                            grant_r <= '0;
                            state   <= IDLE;
                        end else begin
                            // A driver still busy from a previous write must go idle first.
                            ena_r <= !busy_s;
                            armed <= !busy_s;
                            state <= START;
                        end
                    end
                    START: begin
                        if (hit) begin
                            ena_r <= 1'b0;
                            tcnt  <= '0;
                            state <= WAIT;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                            if (!armed && !busy_s) begin
                                armed <= 1'b1;
                                ena_r <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        if (hit) begin
                            last1      <= row1_r;
                            last2      <= row2_r;
                            last_valid <= 1'b1;
                            done_r     <= grant_r;
                            grant_r    <= '0;
                            hcnt       <= '0;
                            state      <= HOLDOFF;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    HOLDOFF: begin
                        if (hcnt == HW'(HOLDOFF_CYC - 1)) begin
                            state <= IDLE;
                        end else begin
                            hcnt <= hcnt + HW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.grant   = grant_r;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.lcd_ena = ena_r;
    assign bus.row1    = row1_r;
    assign bus.row2    = row2_r;

endmodule
